// File: rtl/fetcher_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Opcode constants, default sizes and immediate decoders used by the fetcher.
package fetcher_pkg;

    localparam int unsigned ICACHE_IDX_W_DEF = 8;
    localparam int unsigned BHT_IDX_W_DEF    = 8;

    localparam logic [6:0] JAL_OP = 7'b1101111;
    localparam logic [6:0] B_OP   = 7'b1100011;

    typedef logic [31:0] data_t;

    localparam data_t ZERO_WORD = 32'h0;

    typedef enum logic {
        StIdle,
        StMemWait
    } fetch_state_e;

    function automatic data_t j_imm(input data_t instr);
        return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    function automatic data_t b_imm(input data_t instr);
        return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/fetcher_icache.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Combinational hit/data lookup, synchronous fill, invalidate-all on reset.
module fetcher_icache
    import fetcher_pkg::*;
#(
    parameter int unsigned IDX_W = ICACHE_IDX_W_DEF
) (
    input  logic  clk,
    input  logic  rst,
    input  data_t rd_addr,
    output logic  rd_hit,
    output data_t rd_data,
    input  logic  wr_en,
    input  data_t wr_addr,
    input  data_t wr_data
);

    localparam int unsigned LINES = 1 << IDX_W;
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    data_t            data_mem [LINES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] wr_tag;
    logic             unused_addr_bits;

    assign rd_idx = rd_addr[IDX_W+1:2];
    assign rd_tag = rd_addr[31:IDX_W+2];
    assign wr_idx = wr_addr[IDX_W+1:2];
    assign wr_tag = wr_addr[31:IDX_W+2];

    // Byte offset bits never participate in a word-per-line cache.
    assign unused_addr_bits = ^{rd_addr[1:0], wr_addr[1:0]};

    assign rd_hit  = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_data = data_mem[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/fetcher.sv
// Instruction fetch stage: PC, icache with miss fill, 2-bit BHT prediction,
// one registered instruction per cycle to the decoder, ROB rollback redirect.
module fetcher
    import fetcher_pkg::*;
#(
    parameter int unsigned ICACHE_IDX_W = ICACHE_IDX_W_DEF,
    parameter int unsigned BHT_IDX_W    = BHT_IDX_W_DEF,
    parameter logic [31:0] RESET_PC     = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic [31:0] out_fetcher_instr,
    output logic [31:0] out_fetcher_pc,
    output logic        out_fetcher_jump_flag,
    input  logic        in_rob_full,
    input  logic        in_rs_full,
    input  logic        in_lsb_full,
    input  logic        in_rob_rollback,
    input  logic [31:0] in_rob_target_pc,
    input  logic        in_rob_bht_update,
    input  logic [31:0] in_rob_bht_pc,
    input  logic        in_rob_bht_taken,
    output logic        out_mem_req,
    output logic [31:0] out_mem_addr,
    input  logic        in_mem_ready,
    input  logic [31:0] in_mem_instr
);

    localparam int unsigned BHT_N = 1 << BHT_IDX_W;

    fetch_state_e state;
    data_t        pc;
    data_t        fill_addr;
    logic [1:0]   bht [BHT_N];

    logic                 hit;
    data_t                line;
    logic [6:0]           opcode;
    logic                 pred;
    data_t                next_pc;
    logic                 stall;
    logic                 fill_en;
    logic [BHT_IDX_W-1:0] bht_rd_idx;
    logic [BHT_IDX_W-1:0] bht_wr_idx;
    logic                 unused_bht_pc;

    assign stall      = in_rob_full | in_rs_full | in_lsb_full;
    assign fill_en    = rdy && (state == StMemWait) && in_mem_ready;
    assign bht_rd_idx = pc[BHT_IDX_W+1:2];
    assign bht_wr_idx = in_rob_bht_pc[BHT_IDX_W+1:2];
    assign opcode     = line[6:0];

    assign unused_bht_pc = ^{in_rob_bht_pc[31:BHT_IDX_W+2], in_rob_bht_pc[1:0]};

    fetcher_icache #(
        .IDX_W (ICACHE_IDX_W)
    ) u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_addr (pc),
        .rd_hit  (hit),
        .rd_data (line),
        .wr_en   (fill_en),
        .wr_addr (fill_addr),
        .wr_data (in_mem_instr)
    );

    // JALR is deliberately treated as fall-through; the ROB redirects it.
    always_comb begin
        pred    = 1'b0;
        next_pc = pc + 32'd4;
        if (opcode == JAL_OP) begin
            pred    = 1'b1;
            next_pc = pc + j_imm(line);
        end else if (opcode == B_OP) begin
            pred = bht[bht_rd_idx][1];
            if (pred) begin
                next_pc = pc + b_imm(line);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= StIdle;
            pc                    <= RESET_PC;
            fill_addr             <= ZERO_WORD;
            out_fetcher_instr     <= ZERO_WORD;
            out_fetcher_pc        <= ZERO_WORD;
            out_fetcher_jump_flag <= 1'b0;
            out_mem_req           <= 1'b0;
            out_mem_addr          <= ZERO_WORD;
        end else if (!rdy) begin
            out_fetcher_instr <= ZERO_WORD;
        end else begin
            out_fetcher_instr <= ZERO_WORD;
            case (state)
                StIdle: begin
                    if (in_rob_rollback) begin
                        pc <= in_rob_target_pc;
                    end else if (hit) begin
                        if (!stall) begin
                            out_fetcher_instr     <= line;
                            out_fetcher_pc        <= pc;
                            out_fetcher_jump_flag <= pred;
                            pc                    <= next_pc;
                        end
                    end else begin
                        fill_addr    <= pc;
                        out_mem_req  <= 1'b1;
                        out_mem_addr <= {pc[31:2], 2'b00};
                        state        <= StMemWait;
                    end
                end
                StMemWait: begin
                    // The outstanding request always completes, even after a redirect.
                    if (in_mem_ready) begin
                        out_mem_req <= 1'b0;
                        state       <= StIdle;
                    end
                    if (in_rob_rollback) begin
                        pc <= in_rob_target_pc;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Committed-branch training, saturating at 0 and 3.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (rdy && in_rob_bht_update) begin
            if (in_rob_bht_taken && (bht[bht_wr_idx] != 2'b11)) begin
                bht[bht_wr_idx] <= bht[bht_wr_idx] + 2'b01;
            end else if (!in_rob_bht_taken && (bht[bht_wr_idx] != 2'b00)) begin
                bht[bht_wr_idx] <= bht[bht_wr_idx] - 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_fetcher.sv
// Bench for fetcher: directed timing scenarios, then randomized traffic checked by a
// scoreboard fed from a program-flow reference model.
module tb_fetcher;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [31:0] out_fetcher_instr;
    logic [31:0] out_fetcher_pc;
    logic        out_fetcher_jump_flag;
    logic        in_rob_full;
    logic        in_rs_full;
    logic        in_lsb_full;
    logic        in_rob_rollback;
    logic [31:0] in_rob_target_pc;
    logic        in_rob_bht_update;
    logic [31:0] in_rob_bht_pc;
    logic        in_rob_bht_taken;
    logic        out_mem_req;
    logic [31:0] out_mem_addr;
    logic        in_mem_ready;
    logic [31:0] in_mem_instr;

    fetcher dut (
        .clk                   (clk),
        .rst                   (rst),
        .rdy                   (rdy),
        .out_fetcher_instr     (out_fetcher_instr),
        .out_fetcher_pc        (out_fetcher_pc),
        .out_fetcher_jump_flag (out_fetcher_jump_flag),
        .in_rob_full           (in_rob_full),
        .in_rs_full            (in_rs_full),
        .in_lsb_full           (in_lsb_full),
        .in_rob_rollback       (in_rob_rollback),
        .in_rob_target_pc      (in_rob_target_pc),
        .in_rob_bht_update     (in_rob_bht_update),
        .in_rob_bht_pc         (in_rob_bht_pc),
        .in_rob_bht_taken      (in_rob_bht_taken),
        .out_mem_req           (out_mem_req),
        .out_mem_addr          (out_mem_addr),
        .in_mem_ready          (in_mem_ready),
        .in_mem_instr          (in_mem_instr)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        flag;
    } exp_t;

    // Program region 0x000..0x0FC; kinds: 0 plain, 1 jal, 2 beq, 3 jalr.
    logic [31:0] prog_word [64];
    int          prog_kind [64];
    logic [31:0] prog_tgt  [64];
    int          bht_m     [256];
    exp_t        exp_q     [$];
    logic [31:0] model_pc;

    int n_cmp = 0;
    int n_fail = 0;
    int n_issued = 0;
    int mem_fixed_lat = 0;
    bit mon_en = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] addi_word(input logic [31:0] a);
        return {a[13:2], 5'd1, 3'b000, 5'd1, 7'b0010011};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'h100) return prog_word[a[7:2]];
        return addi_word(a);
    endfunction

    task automatic set_plain(input int i);
        prog_word[i] = addi_word(i * 4);
        prog_kind[i] = 0;
        prog_tgt[i]  = 32'h0;
    endtask

    task automatic set_jal(input int i, input logic [31:0] tgt);
        logic [31:0] imm;
        imm = tgt - 32'(i * 4);
        prog_word[i] = {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
        prog_kind[i] = 1;
        prog_tgt[i]  = tgt;
    endtask

    task automatic set_beq(input int i, input logic [31:0] tgt);
        logic [31:0] imm;
        imm = tgt - 32'(i * 4);
        prog_word[i] = {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'b1100011};
        prog_kind[i] = 2;
        prog_tgt[i]  = tgt;
    endtask

    task automatic set_jalr(input int i);
        prog_word[i] = {12'd0, 5'd1, 3'b000, 5'd0, 7'b1100111};
        prog_kind[i] = 3;
        prog_tgt[i]  = 32'h0;
    endtask

    // Reference model: walk the program from model_pc, appending what should issue.
    task automatic gen_stream(input int n);
        exp_t e;
        int   k;
        for (int i = 0; i < n; i++) begin
            e.pc    = model_pc;
            e.instr = mem_word(model_pc);
            k       = (model_pc < 32'h100) ? prog_kind[model_pc[7:2]] : 0;
            e.flag  = 1'b0;
            if (k == 1) begin
                e.flag   = 1'b1;
                model_pc = prog_tgt[model_pc[7:2]];
            end else if (k == 2 && bht_m[model_pc[9:2]] >= 2) begin
                e.flag   = 1'b1;
                model_pc = prog_tgt[model_pc[7:2]];
            end else begin
                model_pc = model_pc + 32'd4;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic model_bht(input logic [31:0] p, input logic taken);
        if (taken && bht_m[p[9:2]] < 3) bht_m[p[9:2]]++;
        else if (!taken && bht_m[p[9:2]] > 0) bht_m[p[9:2]]--;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_issue(output logic [31:0] p, output logic [31:0] w, output logic f);
        p = 32'hFFFF_FFFF;
        w = 32'h0;
        f = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (out_fetcher_instr != 32'h0) begin
                p = out_fetcher_pc;
                w = out_fetcher_instr;
                f = out_fetcher_jump_flag;
                return;
            end
        end
        n_cmp++;
        n_fail++;
        $display("FAIL wait_issue: got no instruction in 200 cycles, required one");
    endtask

    // Memory controller: answers a pending request after a latency with a one-cycle pulse.
    initial begin
        int cnt;
        bit busy;
        cnt = 0;
        busy = 0;
        in_mem_ready = 1'b0;
        in_mem_instr = 32'h0;
        forever begin
            @(negedge clk);
            if (in_mem_ready) begin
                in_mem_ready = 1'b0;
                busy = 0;
            end else if (out_mem_req) begin
                if (!busy) begin
                    busy = 1;
                    cnt = (mem_fixed_lat >= 0) ? mem_fixed_lat : int'($urandom_range(0, 3));
                end
                if (cnt == 0) begin
                    in_mem_ready = 1'b1;
                    in_mem_instr = mem_word(out_mem_addr);
                end else begin
                    cnt--;
                end
            end else begin
                busy = 0;
            end
        end
    end

    // Monitor: every issued instruction must be allowed and match the scoreboard head.
    initial begin
        bit   gate;
        exp_t e;
        forever begin
            @(posedge clk);
            gate = rdy && !in_rob_full && !in_rs_full && !in_lsb_full && !in_rob_rollback;
            #1;
            if (mon_en && out_fetcher_instr != 32'h0) begin
                n_issued++;
                n_cmp++;
                if (!gate) begin
                    n_fail++;
                    $display("FAIL issue_gate: got issue of pc %h, required none while blocked",
                             out_fetcher_pc);
                end
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_empty: got pc %h instr %h, required no issue",
                             out_fetcher_pc, out_fetcher_instr);
                end else begin
                    e = exp_q.pop_front();
                    if (out_fetcher_pc !== e.pc || out_fetcher_instr !== e.instr ||
                        out_fetcher_jump_flag !== e.flag) begin
                        n_fail++;
                        $display("FAIL sb_issue: got pc %h instr %h flag %b, required pc %h instr %h flag %b",
                                 out_fetcher_pc, out_fetcher_instr, out_fetcher_jump_flag,
                                 e.pc, e.instr, e.flag);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] p, w;
        logic        f;
        logic [31:0] seq [6];
        logic [31:0] stray;
        logic [31:0] rb_tgt;
        logic [31:0] bht_pc;
        int          hits10;
        bit          rb_pend, bht_pend, bht_tk;

        rst = 1'b1;
        rdy = 1'b1;
        in_rob_full = 1'b0;
        in_rs_full = 1'b0;
        in_lsb_full = 1'b0;
        in_rob_rollback = 1'b0;
        in_rob_target_pc = 32'h0;
        in_rob_bht_update = 1'b0;
        in_rob_bht_pc = 32'h0;
        in_rob_bht_taken = 1'b0;

        for (int i = 0; i < 64; i++) set_plain(i);
        set_jal(4, 32'h8);
        set_beq(8, 32'h30);

        // Reset state and cold-start miss timing.
        cyc();
        cyc();
        chk("rst_instr", out_fetcher_instr, 32'h0);
        chk("rst_pc", out_fetcher_pc, 32'h0);
        chk("rst_flag", 32'(out_fetcher_jump_flag), 32'h0);
        chk("rst_req", 32'(out_mem_req), 32'h0);
        chk("rst_addr", out_mem_addr, 32'h0);
        rst = 1'b0;
        cyc();
        chk("cold_req", 32'(out_mem_req), 32'h1);
        chk("cold_addr", out_mem_addr, 32'h0);
        cyc();
        chk("fill_idle_instr", out_fetcher_instr, 32'h0);
        cyc();
        chk("first_instr", out_fetcher_instr, addi_word(32'h0));
        chk("first_pc", out_fetcher_pc, 32'h0);
        chk("first_flag", 32'(out_fetcher_jump_flag), 32'h0);
        cyc();
        chk("second_miss_req", 32'(out_mem_req), 32'h1);
        chk("second_miss_addr", out_mem_addr, 32'h4);

        // Cached loop 0x8 -> 0xC -> 0x10 (JAL -8): one issue per cycle once warm.
        hits10 = 0;
        for (int i = 0; i < 300 && hits10 < 2; i++) begin
            cyc();
            if (out_fetcher_instr != 32'h0 && out_fetcher_pc == 32'h10) hits10++;
        end
        chk("loop_warm", 32'(hits10), 32'd2);
        seq = '{32'h8, 32'hC, 32'h10, 32'h8, 32'hC, 32'h10};
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("loop_pc", out_fetcher_pc, seq[k]);
            chk("loop_flag", 32'(out_fetcher_jump_flag), 32'(seq[k] == 32'h10));
        end

        // Three stalled cycles on a hit; the held instruction issues afterwards.
        in_rs_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_instr", out_fetcher_instr, 32'h0);
        end
        in_rs_full = 1'b0;
        cyc();
        chk("stall_resume_pc", out_fetcher_pc, 32'h8);
        chk("stall_resume_instr", out_fetcher_instr, addi_word(32'h8));

        // Rollback on a hit cycle drops that issue and redirects.
        in_rob_rollback = 1'b1;
        in_rob_target_pc = 32'h20;
        cyc();
        chk("rb_hit_drop", out_fetcher_instr, 32'h0);
        in_rob_rollback = 1'b0;
        wait_issue(p, w, f);
        chk("rb_target_pc", p, 32'h20);
        chk("beq_cold_flag", 32'(f), 32'h0);
        wait_issue(p, w, f);
        chk("beq_not_taken_next", p, 32'h24);

        // Train the BEQ to taken, then check saturation survives one not-taken.
        in_rob_bht_update = 1'b1;
        in_rob_bht_pc = 32'h20;
        in_rob_bht_taken = 1'b1;
        cyc();
        in_rob_rollback = 1'b1;
        cyc();
        in_rob_rollback = 1'b0;
        in_rob_bht_update = 1'b0;
        wait_issue(p, w, f);
        chk("beq_trained_pc", p, 32'h20);
        chk("beq_trained_flag", 32'(f), 32'h1);
        wait_issue(p, w, f);
        chk("beq_taken_next", p, 32'h30);
        in_rob_bht_update = 1'b1;
        cyc();
        cyc();
        cyc();
        in_rob_bht_taken = 1'b0;
        in_rob_rollback = 1'b1;
        cyc();
        in_rob_rollback = 1'b0;
        in_rob_bht_update = 1'b0;
        wait_issue(p, w, f);
        chk("bht_sat_pc", p, 32'h20);
        chk("bht_sat_flag", 32'(f), 32'h1);

        // Rollback during a fill: the fill still lands, nothing from 0x40 issues.
        mem_fixed_lat = 5;
        in_rob_rollback = 1'b1;
        in_rob_target_pc = 32'h40;
        cyc();
        in_rob_rollback = 1'b0;
        for (int i = 0; i < 200 && !(out_mem_req && out_mem_addr == 32'h40); i++) cyc();
        chk("mw_req_40", out_mem_addr, 32'h40);
        in_rob_rollback = 1'b1;
        in_rob_target_pc = 32'h100;
        cyc();
        in_rob_rollback = 1'b0;
        stray = 32'h0;
        for (int i = 0; i < 200 && !(out_mem_req && out_mem_addr != 32'h40); i++) begin
            cyc();
            if (out_fetcher_instr != 32'h0) stray = out_fetcher_pc | 32'h1;
        end
        chk("mw_next_req", out_mem_addr, 32'h100);
        chk("mw_no_issue", stray, 32'h0);
        mem_fixed_lat = 0;
        wait_issue(p, w, f);
        chk("mw_issue_100", p, 32'h100);
        in_rob_rollback = 1'b1;
        in_rob_target_pc = 32'h40;
        cyc();
        in_rob_rollback = 1'b0;
        cyc();
        chk("refetch_40_pc", out_fetcher_pc, 32'h40);
        chk("refetch_40_instr", out_fetcher_instr, addi_word(32'h40));
        chk("refetch_40_no_req", 32'(out_mem_req), 32'h0);

        // Randomized program and traffic against the scoreboard.
        for (int i = 0; i < 64; i++) begin
            case ($urandom % 20)
                0, 1, 2, 3, 4, 5, 6, 7, 8, 9: set_plain(i);
                10, 11, 12: set_jal(i, 32'($urandom_range(0, 63) * 4));
                13, 14, 15, 16, 17: set_beq(i, 32'($urandom_range(0, 63) * 4));
                default: set_jalr(i);
            endcase
        end
        for (int i = 0; i < 256; i++) bht_m[i] = 1;
        mem_fixed_lat = -1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        model_pc = 32'h0;
        gen_stream(64);
        mon_en = 1;
        rb_pend = 0;
        bht_pend = 0;
        bht_tk = 0;
        rb_tgt = 32'h0;
        bht_pc = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (rb_pend) begin
                if (bht_pend) model_bht(bht_pc, bht_tk);
                exp_q.delete();
                model_pc = rb_tgt;
                gen_stream(64);
                rb_pend = 0;
                bht_pend = 0;
            end
            if (exp_q.size() < 32) gen_stream(32);
            rdy = ($urandom % 10) != 0;
            in_rob_full = ($urandom % 8) == 0;
            in_rs_full = ($urandom % 8) == 0;
            in_lsb_full = ($urandom % 8) == 0;
            in_rob_rollback = rdy && (($urandom % 25) == 0);
            in_rob_bht_update = 1'b0;
            if (in_rob_rollback) begin
                rb_tgt = 32'($urandom_range(0, 63) * 4);
                in_rob_target_pc = rb_tgt;
                rb_pend = 1;
                if ($urandom % 2 == 1) begin
                    bht_pc = 32'($urandom_range(0, 63) * 4);
                    bht_tk = $urandom % 2 == 1;
                    in_rob_bht_update = 1'b1;
                    in_rob_bht_pc = bht_pc;
                    in_rob_bht_taken = bht_tk;
                    bht_pend = 1;
                end
            end
        end
        @(negedge clk);
        rdy = 1'b0;
        in_rob_rollback = 1'b0;
        in_rob_bht_update = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mon_en = 0;
        n_cmp++;
        if (n_issued < 300) begin
            n_fail++;
            $display("FAIL rand_throughput: got %0d issues, required at least 300", n_issued);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
